// File: rtl/sevenseg_capture.sv
// sevenseg_capture: recovers per-digit hex nibbles from a multiplexed,
// active-low seven-segment bus plus one-hot digit strobes. A run-length
// filter only commits a digit once its sample has been steady long enough.
// Optional feature macro: SEVENSEG_CAPTURE_ERRCNT_EN adds ERR_CNT / ERR_CLR,
// a saturating count of commits that carried an undecodable pattern.
module sevenseg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [6:0]              SEG,
  input  logic [NUM_DIGITS-1:0]   DIG_SEL,
  output logic [4*NUM_DIGITS-1:0] HEX,
  output logic [NUM_DIGITS-1:0]   BLANK,
  output logic [NUM_DIGITS-1:0]   ERR,
  output logic                    UPD,
  output logic [2:0]              UPD_IDX
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  ,
  input  logic                    ERR_CLR,
  output logic [7:0]              ERR_CNT
`endif
);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;
  localparam logic [7:0] STABLE  = 8'(STABLE_CYCLES);

  // Decoded result packed as {err, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 6'h00;
      7'b1111001: decode = 6'h01;
      7'b0100100: decode = 6'h02;
      7'b0110000: decode = 6'h03;
      7'b0011001: decode = 6'h04;
      7'b0010010: decode = 6'h05;
      7'b0000010: decode = 6'h06;
      7'b1111000: decode = 6'h07;
      7'b0000000: decode = 6'h08;
      7'b0010000: decode = 6'h09;
      7'b0001000: decode = 6'h0A;
      7'b0000011: decode = 6'h0B;
      7'b1000110: decode = 6'h0C;
      7'b0100001: decode = 6'h0D;
      7'b0000110: decode = 6'h0E;
      7'b0001110: decode = 6'h0F;
      7'b1111111: decode = 6'b01_0000;
      default:    decode = 6'b10_0000;
    endcase
  endfunction

  logic [6:0]            s_seg, p_seg;
  logic [NUM_DIGITS-1:0] s_sel, p_sel;
  logic [7:0]            rc, rc_nxt;
  logic [0:0]            state, state_nxt;
  logic                  changed, legal, commit;
  logic [2:0]            idx;
  logic [5:0]            dec;

  // Run-length filter and WAIT/HELD decision on the registered sample
  always_comb begin
    changed   = (s_seg != p_seg) || (s_sel != p_sel);
    legal     = $onehot(s_sel);
    dec       = decode(s_seg);
    rc_nxt    = rc;
    state_nxt = state;
    commit    = 1'b0;
    if (!legal) begin
      rc_nxt    = 8'd0;
      state_nxt = ST_WAIT;
    end else if (changed) begin
      // a change always beats saturation, so never commit on this cycle
      rc_nxt    = 8'd1;
      state_nxt = ST_WAIT;
    end else begin
      rc_nxt = (rc >= STABLE) ? rc : rc + 8'd1;
      if (state == ST_WAIT && rc_nxt == STABLE) begin
        commit    = 1'b1;
        state_nxt = ST_HELD;
      end
    end
  end

  // Index of the selected digit (only meaningful when legal)
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s_sel[i]) idx = 3'(i);
  end

  // Input sample, previous sample, run counter and state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_seg <= 7'h7F;
      s_sel <= '0;
      p_seg <= 7'h7F;
      p_sel <= '0;
      rc    <= 8'd0;
      state <= ST_WAIT;
    end else begin
      s_seg <= SEG;
      s_sel <= DIG_SEL;
      p_seg <= s_seg;
      p_sel <= s_sel;
      rc    <= rc_nxt;
      state <= state_nxt;
    end
  end

  // Commit: overwrite nibble and both flags of the selected digit only
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HEX     <= '0;
      BLANK   <= '1;
      ERR     <= '0;
      UPD     <= 1'b0;
      UPD_IDX <= 3'd0;
    end else begin
      UPD <= commit;
      if (commit) begin
        UPD_IDX <= idx;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_sel[i]) begin
            HEX[4*i +: 4] <= dec[3:0];
            BLANK[i]      <= dec[4];
            ERR[i]        <= dec[5];
          end
        end
      end
    end
  end

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  // Saturating count of committed undecodable patterns; clear wins
  always_ff @(posedge CLK) begin
    if (RESET)                                ERR_CNT <= 8'd0;
    else if (ERR_CLR)                         ERR_CNT <= 8'd0;
    else if (commit && dec[5] && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
  end
`endif

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Inverse of the hex-to-segment encoder. Watches a multiplexed, active-low seven-segment bus plus digit-select strobes and recovers the hex nibble shown on each digit.
- Used on the board-test path. It reads back what the display drivers emit and hands per-digit values, blank flags and error flags to the checker and debug logic.
- A stability filter rejects glitches while digits switch.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; range 2..255.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SEG  in  7  segment bus, active-low; bit0=a ... bit6=g.
- DIG_SEL  in  NUM_DIGITS  one-hot, active-high; marks which digit SEG currently drives.
- HEX  out  4*NUM_DIGITS  decoded nibble per digit; digit i occupies [4i+3:4i].
- BLANK  out  NUM_DIGITS  digit i last captured as all segments off.
- ERR  out  NUM_DIGITS  digit i last captured as a pattern not in the decode table.
- UPD  out  1  single-cycle pulse when a capture is committed.
- UPD_IDX  out  3  index of the digit committed with UPD.

Behaviour:
- Input stage: SEG and DIG_SEL are registered once into the sample S. All logic below operates on S.
- Legal sample: DIG_SEL has exactly one bit set. Zero-hot or multi-hot is illegal. An illegal sample clears the run counter and forces state WAIT. It never captures.
- Run counter RC, 8-bit:
  - RC=1 when S differs from the previous S.
  - Otherwise RC increments, saturating at STABLE_CYCLES.
- States:
  - WAIT: when S is legal and RC reaches STABLE_CYCLES, commit and go to HELD.
  - HELD: stay while S is unchanged; no further commits. Any change in S sets RC=1 and returns to WAIT.
- Latency: a value presented on the pins at edge k and held produces UPD high in the cycle after edge k+STABLE_CYCLES. That is STABLE_CYCLES+1 cycles from presentation.
- Commit, for digit i = index of the set DIG_SEL bit:
  - HEX[i] = decode(SEG).
  - BLANK[i] = (SEG==7'h7F).
  - ERR[i] = pattern not in the table.
  - UPD=1 for exactly one cycle; UPD_IDX=i.
  - Other digits hold their values.
- Decode table, SEG to nibble:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
- Blank: HEX[i]=0, BLANK[i]=1, ERR[i]=0.
- Any other pattern: HEX[i]=0, BLANK[i]=0, ERR[i]=1.
- Same digit recommitted with a new value: HEX, BLANK and ERR for that digit are all overwritten. Flags do not accumulate.
- Reset: HEX=0, BLANK=all 1, ERR=0, UPD=0, UPD_IDX=0, state=WAIT, RC=0, S cleared to SEG=7'h7F and DIG_SEL=0. Reset mid-run discards the partial run; a new run starts from scratch after RESET drops.
- Simultaneous change and saturation: a change in S always wins. No commit occurs on the cycle S changes.

Optional Feature:
- Macro: SEVENSEG_CAPTURE_ERRCNT_EN.
- When defined:
  - Adds output ERR_CNT, out, 8 bits: the number of commits with an illegal segment pattern, saturating at 255.
  - Adds input ERR_CLR, in, 1: synchronous clear. ERR_CLR takes priority over an increment in the same cycle.
  - ERR_CNT resets to 0.
- When undefined: neither port exists. All other behaviour is identical.

Test Plan:
- Reset, then SEG=7'b0100100 with DIG_SEL=4'b0010 held 10 cycles -> one UPD pulse STABLE_CYCLES+1=5 cycles after presentation, UPD_IDX=1, HEX[7:4]=4'h2, BLANK=4'b1101, ERR=0.
- Sweep all 16 table patterns on digit 3, each held 6 cycles -> HEX[15:12] matches each nibble, ERR[3]=0, 16 UPD pulses.
- Glitch: digit 0 presents 7'b1111001 for 3 cycles, then 7'b0000000 for 6 cycles -> no commit for the first pattern, a single commit of 4'h8, UPD asserted once.
- Illegal select: DIG_SEL=4'b0011 or 4'b0000 held 20 cycles with any SEG -> no UPD, outputs unchanged.
- Bad pattern 7'b1010101 on digit 2, then 7'b1111111 -> first commit ERR[2]=1; second commit BLANK[2]=1, ERR[2]=0, HEX[11:8]=0. With the macro defined, ERR_CNT=1; pulsing ERR_CLR -> 0.
- Assert RESET on the 3rd cycle of a stable run of 4'hA on digit 0 -> no UPD; all outputs at reset values; a full run after RESET drops commits normally.
